// File: rtl/wx_frame_accumulator_if.sv
// Single AXI-Stream channel bundle; the accumulator uses one instance per direction.
interface wx_frame_accumulator_if #(
    parameter int DATA_W = 48
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tuser;

    modport master (output tvalid, output tdata, output tuser, input tready);
    modport slave  (input tvalid, input tdata, input tuser, output tready);
endinterface

// File: rtl/wx_frame_accumulator.sv
// Accumulates FRAME_LEN W(x) results into a saturating sum and a running maximum,
// then presents one {max, sum} summary beat per frame.
module wx_frame_accumulator #(
    parameter int FRAME_LEN = 8,
    parameter int SUM_W     = 56
) (
    input  logic                   in_clock,
    input  logic                   in_reset_n,
    wx_frame_accumulator_if.slave  axis_s,
    wx_frame_accumulator_if.master axis_m
);
    localparam int               CNT_W     = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        OUT   = 1'b1
    } state_t;

    state_t              state_reg;
    logic [SUM_W-1:0]    sum_acc_reg;
    logic [47:0]         max_acc_reg;
    logic                sat_flag_reg;
    logic [CNT_W-1:0]    beat_cnt_reg;
    logic [SUM_W+47:0]   out_data_reg;
    logic                out_user_reg;
    logic                m_valid_reg;
    logic                s_ready_reg;

    logic [SUM_W:0]      sum_wide;
    logic [SUM_W-1:0]    sum_next;
    logic [47:0]         max_next;
    logic                sat_next;
    logic                s_fire;
    logic                m_fire;
    logic                unused_tuser;

    // One extra bit catches the carry; once saturated the sum pins at all-ones.
    always_comb begin
        sum_wide = {1'b0, sum_acc_reg} + (SUM_W+1)'(axis_s.tdata);
        sat_next = sat_flag_reg | sum_wide[SUM_W];
        sum_next = sat_next ? {SUM_W{1'b1}} : sum_wide[SUM_W-1:0];
        max_next = (axis_s.tdata > max_acc_reg) ? axis_s.tdata : max_acc_reg;
    end

    assign s_fire = s_ready_reg & axis_s.tvalid;
    assign m_fire = m_valid_reg & axis_m.tready;

    // Ready is registered so it stays low through reset and rises on the first edge after.
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state_reg    <= ACCUM;
            sum_acc_reg  <= '0;
            max_acc_reg  <= '0;
            sat_flag_reg <= 1'b0;
            beat_cnt_reg <= '0;
            out_data_reg <= '0;
            out_user_reg <= 1'b0;
            m_valid_reg  <= 1'b0;
            s_ready_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ACCUM: begin
                    s_ready_reg <= 1'b1;
                    if (s_fire) begin
                        if (beat_cnt_reg == LAST_BEAT) begin
                            out_data_reg <= {max_next, sum_next};
                            out_user_reg <= sat_next;
                            sum_acc_reg  <= '0;
                            max_acc_reg  <= '0;
                            sat_flag_reg <= 1'b0;
                            beat_cnt_reg <= '0;
                            m_valid_reg  <= 1'b1;
                            s_ready_reg  <= 1'b0;
                            state_reg    <= OUT;
                        end else begin
                            sum_acc_reg  <= sum_next;
                            max_acc_reg  <= max_next;
                            sat_flag_reg <= sat_next;
                            beat_cnt_reg <= beat_cnt_reg + 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (m_fire) begin
                        m_valid_reg <= 1'b0;
                        s_ready_reg <= 1'b1;
                        state_reg   <= ACCUM;
                    end
                end
                default: begin
                    state_reg   <= ACCUM;
                    m_valid_reg <= 1'b0;
                    s_ready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign axis_s.tready = s_ready_reg;
    assign axis_m.tvalid = m_valid_reg;
    assign axis_m.tdata  = out_data_reg;
    assign axis_m.tuser  = out_user_reg;
    assign unused_tuser  = axis_s.tuser;
endmodule

// File: tb/tb_wx_frame_accumulator.sv
// Self-checking bench: table-driven frames, hand-written corner sequences and a
// randomized run scored against a frame-level arithmetic model.
`timescale 1ns/1ps
module tb_wx_frame_accumulator;
    logic in_clock   = 1'b0;
    logic in_reset_n = 1'b0;
    always #5 in_clock = ~in_clock;

    wx_frame_accumulator_if #(.DATA_W(48))  a_s ();
    wx_frame_accumulator_if #(.DATA_W(104)) a_m ();
    wx_frame_accumulator_if #(.DATA_W(48))  b_s ();
    wx_frame_accumulator_if #(.DATA_W(97))  b_m ();

    wx_frame_accumulator #(.FRAME_LEN(8), .SUM_W(56)) dut_a (
        .in_clock  (in_clock),
        .in_reset_n(in_reset_n),
        .axis_s    (a_s),
        .axis_m    (a_m)
    );

    wx_frame_accumulator #(.FRAME_LEN(4), .SUM_W(49)) dut_b (
        .in_clock  (in_clock),
        .in_reset_n(in_reset_n),
        .axis_s    (b_s),
        .axis_m    (b_m)
    );

    int checks   = 0;
    int failures = 0;
    bit rand_done;

    localparam logic [63:0] SUM_LIMIT = 64'h00FF_FFFF_FFFF_FFFF;

    typedef struct packed {
        logic [55:0] sum;
        logic [47:0] max;
        logic        user;
    } exp_t;

    typedef struct {
        logic [47:0] v [8];
        logic [55:0] sum;
        logic [47:0] max;
        logic        user;
        bit          gapped;
    } vec_t;

    logic [47:0] frame_q [$];
    exp_t        exp_q   [$];

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // Frame-level model: saturating total and maximum of each FRAME_LEN accepted values.
    always @(negedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            frame_q.delete();
            exp_q.delete();
        end else begin
            if (a_m.tvalid && a_m.tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL mon_unexpected_summary actual=%0h required=none", a_m.tdata);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("summary sum=%0d max=%0d tuser=%0b", a_m.tdata[55:0], a_m.tdata[103:56], a_m.tuser);
                    check("mon_sum",  128'(a_m.tdata[55:0]),   128'(e.sum));
                    check("mon_max",  128'(a_m.tdata[103:56]), 128'(e.max));
                    check("mon_user", 128'(a_m.tuser),         128'(e.user));
                end
            end
            if (a_s.tvalid && a_s.tready) begin
                frame_q.push_back(a_s.tdata);
                if (frame_q.size() == 8) begin
                    logic [63:0] total;
                    exp_t        e;
                    total = '0;
                    e.max = '0;
                    foreach (frame_q[i]) begin
                        total = total + 64'(frame_q[i]);
                        if (frame_q[i] > e.max) e.max = frame_q[i];
                    end
                    e.user = (total > SUM_LIMIT);
                    e.sum  = e.user ? SUM_LIMIT[55:0] : total[55:0];
                    exp_q.push_back(e);
                    frame_q.delete();
                end
            end
        end
    end

    task automatic send_a(input logic [47:0] v, input int gap, output int cyc);
        logic rdy;
        a_s.tvalid = 1'b0;
        repeat (gap) begin @(posedge in_clock); #1; end
        a_s.tvalid = 1'b1;
        a_s.tdata  = v;
        cyc = 0;
        rdy = 1'b0;
        while (!rdy && cyc < 200) begin
            @(negedge in_clock);
            rdy = a_s.tready;
            @(posedge in_clock); #1;
            cyc++;
        end
        a_s.tvalid = 1'b0;
        if (!rdy) begin
            checks++; failures++;
            $display("FAIL send_a_timeout actual=not_accepted required=accepted");
        end
    endtask

    task automatic send_b(input logic [47:0] v);
        logic rdy;
        int   cyc;
        b_s.tvalid = 1'b1;
        b_s.tdata  = v;
        cyc = 0;
        rdy = 1'b0;
        while (!rdy && cyc < 200) begin
            @(negedge in_clock);
            rdy = b_s.tready;
            @(posedge in_clock); #1;
            cyc++;
        end
        b_s.tvalid = 1'b0;
        if (!rdy) begin
            checks++; failures++;
            $display("FAIL send_b_timeout actual=not_accepted required=accepted");
        end
    endtask

    task automatic get_a(output logic [103:0] d, output logic u, output int waits);
        bit seen;
        seen = 1'b0; waits = 0; d = '0; u = 1'b0;
        while (!seen && waits < 200) begin
            @(negedge in_clock);
            waits++;
            if (a_m.tvalid) begin seen = 1'b1; d = a_m.tdata; u = a_m.tuser; end
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL get_a_timeout actual=no_tvalid required=tvalid");
        end
        @(posedge in_clock); #1;
    endtask

    task automatic get_b(output logic [96:0] d, output logic u);
        bit seen;
        int waits;
        seen = 1'b0; waits = 0; d = '0; u = 1'b0;
        while (!seen && waits < 200) begin
            @(negedge in_clock);
            waits++;
            if (b_m.tvalid) begin seen = 1'b1; d = b_m.tdata; u = b_m.tuser; end
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL get_b_timeout actual=no_tvalid required=tvalid");
        end
        @(posedge in_clock); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t         tbl [5];
        logic [103:0] d;
        logic [96:0]  db;
        logic         u;
        int           waits, cyc, total_cyc, n;
        logic [63:0]  r;
        logic [47:0]  v;

        tbl[0].v = '{48'd1, 48'd5, 48'd19, 48'd49, 48'd101, 48'd181, 48'd295, 48'd449};
        tbl[0].sum = 56'd1100; tbl[0].max = 48'd449; tbl[0].user = 1'b0; tbl[0].gapped = 1'b0;
        tbl[1].v = '{48'd1, 48'd5, 48'd19, 48'd49, 48'd101, 48'd181, 48'd295, 48'd449};
        tbl[1].sum = 56'd1100; tbl[1].max = 48'd449; tbl[1].user = 1'b0; tbl[1].gapped = 1'b1;
        tbl[2].v = '{48'd0, 48'd0, 48'd0, 48'd0, 48'd0, 48'd0, 48'd0, 48'd0};
        tbl[2].sum = 56'd0; tbl[2].max = 48'd0; tbl[2].user = 1'b0; tbl[2].gapped = 1'b0;
        tbl[3].v = '{48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF,
                     48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF};
        tbl[3].sum = 56'h07_FFFF_FFFF_FFF8; tbl[3].max = 48'hFFFF_FFFF_FFFF; tbl[3].user = 1'b0; tbl[3].gapped = 1'b1;
        tbl[4].v = '{48'd10, 48'd200, 48'd30, 48'd4000, 48'd5, 48'd60, 48'd7, 48'd80};
        tbl[4].sum = 56'd4392; tbl[4].max = 48'd4000; tbl[4].user = 1'b0; tbl[4].gapped = 1'b1;

        a_s.tvalid = 1'b0; a_s.tdata = '0; a_s.tuser = 1'b0; a_m.tready = 1'b1;
        b_s.tvalid = 1'b0; b_s.tdata = '0; b_s.tuser = 1'b0; b_m.tready = 1'b1;
        rand_done = 1'b0;

        // Reset state
        #12;
        check("rst_s_tready", 128'(a_s.tready), 128'(0));
        check("rst_m_tvalid", 128'(a_m.tvalid), 128'(0));
        check("rst_m_tdata",  128'(a_m.tdata),  128'(0));
        check("rst_m_tuser",  128'(a_m.tuser),  128'(0));
        #10 in_reset_n = 1'b1;
        @(posedge in_clock); #1;
        @(negedge in_clock);
        check("ready_after_reset", 128'(a_s.tready), 128'(1));
        @(posedge in_clock); #1;

        // Table-driven frames
        for (int k = 0; k < 5; k++) begin
            total_cyc = 0;
            for (int i = 0; i < 8; i++) begin
                send_a(tbl[k].v[i], tbl[k].gapped ? int'($urandom_range(0, 3)) : 0, cyc);
                total_cyc += cyc;
            end
            if (!tbl[k].gapped) check($sformatf("vec%0d_b2b_cycles", k), 128'(total_cyc), 128'(8));
            get_a(d, u, waits);
            check($sformatf("vec%0d_latency", k), 128'(waits), 128'(1));
            check($sformatf("vec%0d_sum", k),  128'(d[55:0]),   128'(tbl[k].sum));
            check($sformatf("vec%0d_max", k),  128'(d[103:56]), 128'(tbl[k].max));
            check($sformatf("vec%0d_user", k), 128'(u),         128'(tbl[k].user));
            @(negedge in_clock);
            check($sformatf("vec%0d_valid_one_cycle", k), 128'(a_m.tvalid), 128'(0));
            @(posedge in_clock); #1;
        end

        // Backpressure: summary held for 10 cycles while upstream offers a beat
        a_m.tready = 1'b0;
        for (int i = 0; i < 8; i++) send_a(48'(i * 1000 + 3), 0, cyc);
        a_s.tvalid = 1'b1;
        a_s.tdata  = 48'd777;
        @(negedge in_clock);
        d = a_m.tdata;
        u = a_m.tuser;
        check("bp_sum", 128'(d[55:0]),   128'(28024));
        check("bp_max", 128'(d[103:56]), 128'(7003));
        for (int i = 0; i < 10; i++) begin
            @(negedge in_clock);
            check("bp_valid_held", 128'(a_m.tvalid), 128'(1));
            check("bp_data_held",  128'(a_m.tdata),  128'(d));
            check("bp_user_held",  128'(a_m.tuser),  128'(u));
            check("bp_s_stalled",  128'(a_s.tready), 128'(0));
        end
        @(posedge in_clock); #1;
        a_m.tready = 1'b1;
        @(negedge in_clock);
        check("bp_release_valid", 128'(a_m.tvalid), 128'(1));
        @(posedge in_clock); #1;
        @(negedge in_clock);
        check("bp_s_ready_after", 128'(a_s.tready), 128'(1));
        check("bp_valid_dropped", 128'(a_m.tvalid), 128'(0));
        @(posedge in_clock); #1;
        a_s.tvalid = 1'b0;
        for (int i = 0; i < 7; i++) send_a(48'd1, 0, cyc);
        get_a(d, u, waits);
        check("bp_next_sum", 128'(d[55:0]),   128'(784));
        check("bp_next_max", 128'(d[103:56]), 128'(777));

        // Randomized frames with random downstream readiness
        fork
            begin
                for (int f = 0; f < 15; f++) begin
                    for (int i = 0; i < 8; i++) begin
                        r = {$urandom(), $urandom()};
                        v = ((f + i) % 3 == 0) ? r[47:0] : 48'($urandom_range(0, 5000));
                        send_a(v, int'($urandom_range(0, 2)), cyc);
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge in_clock); #1;
                    a_m.tready = 1'($urandom_range(0, 1));
                end
                a_m.tready = 1'b1;
            end
        join
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge in_clock);
            n++;
        end
        check("rand_drained", 128'(exp_q.size()), 128'(0));
        @(posedge in_clock); #1;
        @(negedge in_clock);
        check("rand_idle_valid", 128'(a_m.tvalid), 128'(0));
        @(posedge in_clock); #1;

        // Reset mid-frame discards the partial frame
        for (int i = 0; i < 3; i++) send_a(48'd1000, 0, cyc);
        #1 in_reset_n = 1'b0;
        #1;
        check("midrst_s_tready", 128'(a_s.tready), 128'(0));
        check("midrst_m_tvalid", 128'(a_m.tvalid), 128'(0));
        check("midrst_m_tdata",  128'(a_m.tdata),  128'(0));
        #1 in_reset_n = 1'b1;
        @(posedge in_clock); #1;
        @(negedge in_clock);
        check("midrst_ready_after", 128'(a_s.tready), 128'(1));
        check("midrst_no_output",   128'(a_m.tvalid), 128'(0));
        @(posedge in_clock); #1;
        for (int i = 0; i < 8; i++) send_a(48'd1, 0, cyc);
        get_a(d, u, waits);
        check("midrst_sum",  128'(d[55:0]),   128'(8));
        check("midrst_max",  128'(d[103:56]), 128'(1));
        check("midrst_user", 128'(u),         128'(0));

        // Saturation on the narrow instance, then a clean frame
        for (int i = 0; i < 4; i++) send_b(48'hFFFF_FFFF_FFFF);
        get_b(db, u);
        $display("summary_b sum=%0h max=%0h tuser=%0b", db[48:0], db[96:49], u);
        check("sat_sum",  128'(db[48:0]),  128'(49'h1_FFFF_FFFF_FFFF));
        check("sat_max",  128'(db[96:49]), 128'(48'hFFFF_FFFF_FFFF));
        check("sat_user", 128'(u),         128'(1));
        for (int i = 0; i < 4; i++) send_b(48'd1);
        get_b(db, u);
        $display("summary_b sum=%0h max=%0h tuser=%0b", db[48:0], db[96:49], u);
        check("sat_next_sum",  128'(db[48:0]),  128'(4));
        check("sat_next_max",  128'(db[96:49]), 128'(1));
        check("sat_next_user", 128'(u),         128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
